// File: rtl/hba_gpio_ext_pkg.sv
// Shared definitions for the HBA GPIO peripheral: register map and bus FSM states.
package hba_gpio_ext_pkg;

  localparam int unsigned REG_PINS = 0;
  localparam int unsigned REG_OUT  = 1;
  localparam int unsigned REG_DIR  = 2;
  localparam int unsigned REG_IE   = 3;
  localparam int unsigned REG_RISE = 4;
  localparam int unsigned REG_FALL = 5;
  localparam int unsigned REG_STAT = 6;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2,
    BUS_WAIT  = 2'd3
  } bus_state_e;

endpackage

// File: rtl/hba_sync_edge.sv
// Multi-stage input synchroniser with a one-cycle history register for
// per-bit rising/falling edge pulses.
module hba_sync_edge #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             hba_clk,
  input  logic             hba_reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain_reg [STAGES];
  logic [WIDTH-1:0] prev_reg;

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      for (int s = 0; s < STAGES; s++) begin
        chain_reg[s] <= '0;
      end
      prev_reg <= '0;
    end else begin
      chain_reg[0] <= async_in;
      for (int s = 1; s < STAGES; s++) begin
        chain_reg[s] <= chain_reg[s-1];
      end
      // History always follows the synchronised value, so it never holds stale data
      prev_reg <= sync_out;
    end
  end

  assign sync_out = chain_reg[STAGES-1];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign rise[gi] = sync_out[gi] & ~prev_reg[gi];
      assign fall[gi] = ~sync_out[gi] & prev_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/hba_gpio_ext.sv
// HBA slave GPIO peripheral: address decode, bus handshake FSM, pin register file,
// sticky edge-status flags and registered interrupt output.
module hba_gpio_ext #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_PINS          = 8,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] gpio_dbus,
  output logic                  gpio_xferack,
  output logic                  gpio_interrupt,
  output logic [NUM_PINS-1:0]   gpio_out_en,
  output logic [NUM_PINS-1:0]   gpio_out_sig,
  input  logic [NUM_PINS-1:0]   gpio_in_sig
);

  import hba_gpio_ext_pkg::*;

  generate
    if (NUM_PINS < 1 || NUM_PINS > DBUS_WIDTH) begin : g_bad_num_pins
      $error("hba_gpio_ext: NUM_PINS must be in 1..DBUS_WIDTH");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("hba_gpio_ext: SYNC_STAGES must be at least 2");
    end
  endgenerate

  localparam logic [REG_ADDR_WIDTH-1:0] A_PINS = REG_ADDR_WIDTH'(REG_PINS);
  localparam logic [REG_ADDR_WIDTH-1:0] A_OUT  = REG_ADDR_WIDTH'(REG_OUT);
  localparam logic [REG_ADDR_WIDTH-1:0] A_DIR  = REG_ADDR_WIDTH'(REG_DIR);
  localparam logic [REG_ADDR_WIDTH-1:0] A_IE   = REG_ADDR_WIDTH'(REG_IE);
  localparam logic [REG_ADDR_WIDTH-1:0] A_RISE = REG_ADDR_WIDTH'(REG_RISE);
  localparam logic [REG_ADDR_WIDTH-1:0] A_FALL = REG_ADDR_WIDTH'(REG_FALL);
  localparam logic [REG_ADDR_WIDTH-1:0] A_STAT = REG_ADDR_WIDTH'(REG_STAT);

  logic [PERIPH_ADDR_WIDTH-1:0] periph_sel;
  logic [REG_ADDR_WIDTH-1:0]    reg_sel;
  logic                         addr_decode_hit;
  logic                         addr_hit_reg;

  bus_state_e                   state_reg, state_next;
  logic                         xferack_reg, xferack_next;
  logic [DBUS_WIDTH-1:0]        dbus_reg, dbus_next;
  logic                         wr_en;

  logic [NUM_PINS-1:0] out_reg, dir_reg, ie_reg, rise_en_reg, fall_en_reg, stat_reg;
  logic [NUM_PINS-1:0] stat_next, stat_set, stat_clr;
  logic                irq_reg;

  logic [NUM_PINS-1:0] wdata;
  logic [NUM_PINS-1:0] rd_pins;
  logic [NUM_PINS-1:0] pins_value;
  logic [DBUS_WIDTH-1:0] read_data;

  logic [NUM_PINS-1:0] sync_in, pin_rise, pin_fall;

  hba_sync_edge #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .hba_clk   (hba_clk),
    .hba_reset (hba_reset),
    .async_in  (gpio_in_sig),
    .sync_out  (sync_in),
    .rise      (pin_rise),
    .fall      (pin_fall)
  );

  assign periph_sel      = hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH];
  assign reg_sel         = hba_abus[REG_ADDR_WIDTH-1:0];
  assign addr_decode_hit = (periph_sel == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
  assign wdata           = hba_dbus[NUM_PINS-1:0];

  // Masking with the ack stops a held select from re-launching the transfer
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      addr_hit_reg <= 1'b0;
      state_reg    <= BUS_IDLE;
      xferack_reg  <= 1'b0;
      dbus_reg     <= '0;
    end else begin
      addr_hit_reg <= addr_decode_hit & hba_select & ~xferack_reg;
      state_reg    <= state_next;
      xferack_reg  <= xferack_next;
      dbus_reg     <= dbus_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    xferack_next = 1'b0;
    dbus_next    = '0;
    wr_en        = 1'b0;
    case (state_reg)
      BUS_IDLE: begin
        if (addr_hit_reg) begin
          state_next = hba_rnw ? BUS_READ : BUS_WRITE;
        end
      end
      BUS_READ: begin
        xferack_next = 1'b1;
        dbus_next    = read_data;
        state_next   = BUS_WAIT;
      end
      BUS_WRITE: begin
        xferack_next = 1'b1;
        wr_en        = 1'b1;
        state_next   = BUS_WAIT;
      end
      BUS_WAIT: begin
        state_next = BUS_IDLE;
      end
      default: begin
        state_next = BUS_IDLE;
      end
    endcase
  end

  assign pins_value = (dir_reg & out_reg) | (~dir_reg & sync_in);

  always_comb begin
    rd_pins = '0;
    case (reg_sel)
      A_PINS:  rd_pins = pins_value;
      A_OUT:   rd_pins = out_reg;
      A_DIR:   rd_pins = dir_reg;
      A_IE:    rd_pins = ie_reg;
      A_RISE:  rd_pins = rise_en_reg;
      A_FALL:  rd_pins = fall_en_reg;
      A_STAT:  rd_pins = stat_reg;
      default: rd_pins = '0;
    endcase
    read_data = '0;
    read_data[NUM_PINS-1:0] = rd_pins;
  end

  // Output pins never raise a flag; a newly set flag beats a same-cycle clear
  assign stat_set  = ((pin_rise & rise_en_reg) | (pin_fall & fall_en_reg)) & ~dir_reg;
  assign stat_clr  = (wr_en && reg_sel == A_STAT) ? wdata : '0;
  assign stat_next = (stat_reg & ~stat_clr) | stat_set;

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      out_reg     <= '0;
      dir_reg     <= '0;
      ie_reg      <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      stat_reg    <= '0;
      irq_reg     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          A_PINS, A_OUT: out_reg     <= wdata;
          A_DIR:         dir_reg     <= wdata;
          A_IE:          ie_reg      <= wdata;
          A_RISE:        rise_en_reg <= wdata;
          A_FALL:        fall_en_reg <= wdata;
          default:       ;
        endcase
      end
      stat_reg <= stat_next;
      irq_reg  <= |(stat_reg & ie_reg);
    end
  end

  assign gpio_dbus      = dbus_reg;
  assign gpio_xferack   = xferack_reg;
  assign gpio_interrupt = irq_reg;
  assign gpio_out_en    = dir_reg;
  assign gpio_out_sig   = out_reg;

endmodule
